// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main controller: Moore state machine for instruction sequencing
// plus the ALU decoder that turns op/funct into the datapath's ALU function code.
module mips_mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               immext,
  output logic [1:0]         pcsrc,
  output logic [3:0]         alucontrol,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] FETCH   = STATE_W'(0);
  localparam logic [STATE_W-1:0] DECODE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(3);
  localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] RTYPEEX = STATE_W'(6);
  localparam logic [STATE_W-1:0] RTYPEWB = STATE_W'(7);
  localparam logic [STATE_W-1:0] BEQEX   = STATE_W'(8);
  localparam logic [STATE_W-1:0] IMMEX   = STATE_W'(9);
  localparam logic [STATE_W-1:0] IMMWB   = STATE_W'(10);
  localparam logic [STATE_W-1:0] JEX     = STATE_W'(11);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [STATE_W-1:0] next_state;
  logic               pcwrite;
  logic               branch;
  logic               bne;
  logic               funct_ok;
  logic [3:0]         funct_alu;

  // R-type funct decode; funct_ok gates entry to RTYPEEX from DECODE.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    immext     = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = ALU_AND;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        // ALU precomputes the branch target into ALUOut while op is decoded.
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW:            next_state = MEMADR;
          OP_BEQ, OP_BNE:          next_state = BEQEX;
          OP_ADDI, OP_ANDI, OP_ORI: next_state = IMMEX;
          OP_J:                    next_state = JEX;
          OP_R: begin
            if (funct_ok) next_state = RTYPEEX;
            else          illegal    = 1'b1;
          end
          default:                 illegal    = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        next_state = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord       = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        next_state = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        bne        = (op == OP_BNE);
      end
      IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = IMMWB;
        case (op)
          OP_ANDI: begin alucontrol = ALU_AND; immext = 1'b1; end
          OP_ORI:  begin alucontrol = ALU_OR;  immext = 1'b1; end
          default: alucontrol = ALU_ADD;
        endcase
      end
      IMMWB: begin
        regwrite   = 1'b1;
      end
      JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  assign pcen = pcwrite | (branch & (zero ^ bne));

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized instruction stream against a per-instruction phase model of the
// multicycle controller; outputs are compared every cycle at the falling edge.
module tb_mips_mc_controller;

  localparam int W = 22;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb;
  logic       immext;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  mips_mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .immext(immext), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb;
    logic       immext;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       illegal;
    logic [3:0] state;
  } obs_t;

  // Debug state codes as exposed on the state port.
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                 P_MEMWR = 5, P_RTYPEEX = 6, P_RTYPEWB = 7, P_BEQEX = 8, P_IMMEX = 9,
                 P_IMMWB = 10, P_JEX = 11;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_J = 6'h02;

  logic [W-1:0] exp_q[$];
  obs_t         actual;
  int           checks = 0;
  int           passes = 0;

  assign actual = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                   alusrcb, immext, pcsrc, alucontrol, illegal, state};

  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'bxxxx;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
    if (o == OP_R) return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
                          (f == 6'b100101) || (f == 6'b101010);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) || (o == OP_BNE) ||
           (o == OP_ADDI) || (o == OP_ANDI) || (o == OP_ORI) || (o == OP_J);
  endfunction

  function automatic int instr_len(input logic [5:0] o, input logic [5:0] f);
    if (!legal(o, f)) return 2;
    if (o == OP_LW) return 5;
    if (o == OP_BEQ || o == OP_BNE || o == OP_J) return 3;
    return 4;
  endfunction

  function automatic int phase_at(input logic [5:0] o, input logic [5:0] f, input int k);
    if (k == 0) return P_FETCH;
    if (k == 1) return P_DECODE;
    case (o)
      OP_LW:                    return (k == 2) ? P_MEMADR : (k == 3) ? P_MEMRD : P_MEMWB;
      OP_SW:                    return (k == 2) ? P_MEMADR : P_MEMWR;
      OP_R:                     return (k == 2) ? P_RTYPEEX : P_RTYPEWB;
      OP_BEQ, OP_BNE:           return P_BEQEX;
      OP_ADDI, OP_ANDI, OP_ORI: return (k == 2) ? P_IMMEX : P_IMMWB;
      OP_J:                     return P_JEX;
      default:                  return P_FETCH;
    endcase
  endfunction

  function automatic logic [W-1:0] model(input int ph, input logic [5:0] o,
                                         input logic [5:0] f, input logic z);
    obs_t e;
    e = '0;
    e.state = 4'(ph);
    case (ph)
      P_FETCH:   begin e.alusrcb = 2'b01; e.alucontrol = 4'b0010; e.irwrite = 1; e.pcen = 1; end
      P_DECODE:  begin e.alusrcb = 2'b11; e.alucontrol = 4'b0010; e.illegal = !legal(o, f); end
      P_MEMADR:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 4'b0010; end
      P_MEMRD:   e.iord = 1;
      P_MEMWB:   begin e.memtoreg = 1; e.regwrite = 1; end
      P_MEMWR:   begin e.iord = 1; e.memwrite = 1; end
      P_RTYPEEX: begin e.alusrca = 1; e.alucontrol = r_alu(f); end
      P_RTYPEWB: begin e.regdst = 1; e.regwrite = 1; end
      P_BEQEX: begin
        e.alusrca = 1; e.alucontrol = 4'b0110; e.pcsrc = 2'b01;
        e.pcen = (o == OP_BNE) ? !z : z;
      end
      P_IMMEX: begin
        e.alusrca = 1; e.alusrcb = 2'b10;
        if (o == OP_ADDI)      e.alucontrol = 4'b0010;
        else if (o == OP_ANDI) begin e.alucontrol = 4'b0000; e.immext = 1; end
        else                   begin e.alucontrol = 4'b0001; e.immext = 1; end
      end
      P_IMMWB:   e.regwrite = 1;
      P_JEX:     begin e.pcsrc = 2'b10; e.pcen = 1; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // Called aligned 1ns after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    for (int k = 0; k < instr_len(o, f); k++) begin
      zero = 1'($urandom_range(0, 1));
      exp_q.push_back(model(phase_at(o, f, k), o, f, zero));
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (actual === e) passes++;
      else $display("FAIL cycle t=%0t op=%b funct=%b zero=%b actual=%h expected=%h",
                    $time, op, funct, zero, actual, e);
    end
  end

  initial begin
    obs_t m;
    logic [5:0] ops[10];
    logic [5:0] functs[5];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J, 6'h3F};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Hand-computed pins on the model itself.
    m = model(P_RTYPEEX, OP_R, 6'b101010, 0);
    check("pin_slt_alu", 32'(m.alucontrol), 32'h7);
    m = model(P_BEQEX, OP_BEQ, 6'h00, 1);
    check("pin_beq_z1", 32'({m.pcen, m.pcsrc}), 32'b101);
    m = model(P_BEQEX, OP_BNE, 6'h00, 1);
    check("pin_bne_z1", 32'(m.pcen), 32'h0);
    m = model(P_IMMEX, OP_ORI, 6'h00, 0);
    check("pin_ori", 32'({m.alucontrol, m.immext, m.alusrcb}), 32'b0001_1_10);
    m = model(P_DECODE, 6'h3F, 6'h00, 0);
    check("pin_illegal_op", 32'(m.illegal), 32'h1);
    m = model(P_DECODE, OP_R, 6'h00, 0);
    check("pin_illegal_funct", 32'(m.illegal), 32'h1);
    check("pin_len_lw", 32'(instr_len(OP_LW, 6'h00)), 32'd5);
    check("pin_len_beq", 32'(instr_len(OP_BEQ, 6'h00)), 32'd3);
    check("pin_len_ill", 32'(instr_len(6'h3F, 6'h00)), 32'd2);

    reset = 1'b1;
    op = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'h0);
    check("reset_fetch_outs", 32'({irwrite, pcen, alusrcb, alucontrol, regwrite, memwrite}),
          32'b1_1_01_0010_0_0);
    reset = 1'b0;

    run_instr(OP_LW, 6'h00);
    run_instr(OP_SW, 6'h00);
    run_instr(OP_R, 6'b101010);
    run_instr(OP_R, 6'b100010);
    run_instr(OP_BEQ, 6'h00);
    run_instr(OP_BNE, 6'h00);
    run_instr(OP_ORI, 6'h00);
    run_instr(OP_ANDI, 6'h00);
    run_instr(OP_ADDI, 6'h00);
    run_instr(OP_J, 6'h00);
    run_instr(6'h3F, 6'h00);
    run_instr(OP_R, 6'h00);

    // Async reset in the middle of a load's MEMRD cycle.
    op = OP_LW;
    funct = 6'h00;
    for (int k = 0; k < 3; k++) begin
      zero = 1'($urandom_range(0, 1));
      exp_q.push_back(model(phase_at(OP_LW, 6'h00, k), OP_LW, 6'h00, zero));
      @(posedge clk);
      #1;
    end
    #1;
    reset = 1'b1;
    #1;
    check("midreset_state", 32'(state), 32'h0);
    check("midreset_outs", 32'({irwrite, pcen, alusrcb, alucontrol, iord, regwrite}),
          32'b1_1_01_0010_0_0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int n = 0; n < 400; n++) begin
      logic [5:0] o;
      logic [5:0] f;
      o = ops[$urandom_range(0, 9)];
      if (o == 6'h3F) o = 6'($urandom_range(0, 63));
      f = ($urandom_range(0, 7) < 6) ? functs[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
      run_instr(o, f);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
